// File: rtl/bf2_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback butterfly stage.
// Registered outputs; stall, frame resync, optional halving and flush drain.
module bf2_sdf_stage #(
    parameter int IN_W  = 9,
    parameter int DELAY = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [IN_W-1:0]   din_re,
    input  logic [IN_W-1:0]   din_im,
    input  logic              valid_in,
    input  logic              sof_in,
    input  logic              scale_en,
    input  logic              flush,
    output logic [IN_W:0]     dout_re,
    output logic [IN_W:0]     dout_im,
    output logic              valid_out,
    output logic              sof_out,
    output logic              busy,
    output logic              err_resync
);

    localparam int OUT_W = IN_W + 1;
    localparam int AW    = $clog2(DELAY);
    localparam int CW    = AW + 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             primed_q, primed_d;
    logic [OUT_W-1:0] dout_re_q, dout_re_d;
    logic [OUT_W-1:0] dout_im_q, dout_im_d;
    logic             valid_out_q, valid_out_d;
    logic             sof_out_q, sof_out_d;
    logic             err_q, err_d;

    logic [OUT_W-1:0] mem_re [DELAY];
    logic [OUT_W-1:0] mem_im [DELAY];

    logic             adv, resync, second, wr_en;
    logic [OUT_W-1:0] x_re, x_im, d_re, d_im;
    logic [OUT_W-1:0] push_re, push_im, res_re, res_im;

    // Round-half-up halving done one bit wider so v+1 cannot wrap.
    function automatic logic [OUT_W-1:0] scl(
        input logic [OUT_W-1:0] v,
        input logic             en
    );
        logic signed [OUT_W:0] t;
        t = $signed({v[OUT_W-1], v}) + $signed((OUT_W+1)'(1));
        t = t >>> 1;
        return en ? t[OUT_W-1:0] : v;
    endfunction

    always_comb begin
        adv    = (state_q == FLUSH) || valid_in;
        resync = (state_q == RUN) && valid_in && sof_in
                 && (cnt_q != '0);
        second = !resync && (state_q == RUN)
                 && (cnt_q >= CW'(DELAY));

        x_re = '0;
        x_im = '0;
        if (state_q == RUN) begin
            x_re = {din_re[IN_W-1], din_re};
            x_im = {din_im[IN_W-1], din_im};
        end

        d_re    = mem_re[ptr_q];
        d_im    = mem_im[ptr_q];
        push_re = second ? d_re - x_re : x_re;
        push_im = second ? d_im - x_im : x_im;
        res_re  = second ? d_re + x_re : d_re;
        res_im  = second ? d_im + x_im : d_im;

        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        primed_d    = primed_q;
        dout_re_d   = dout_re_q;
        dout_im_d   = dout_im_q;
        valid_out_d = 1'b0;
        sof_out_d   = 1'b0;
        err_d       = 1'b0;
        wr_en       = 1'b0;

        if (adv) begin
            wr_en       = 1'b1;
            ptr_d       = ptr_q + 1'b1;
            dout_re_d   = scl(res_re, scale_en);
            dout_im_d   = scl(res_im, scale_en);
            valid_out_d = second || (state_q == FLUSH)
                          || (primed_q && !resync);
            sof_out_d   = second && (cnt_q == CW'(DELAY));
            if (resync) begin
                cnt_d    = CW'(1);
                primed_d = 1'b0;
                err_d    = 1'b1;
            end else if (state_q == FLUSH
                         && cnt_q == CW'(DELAY-1)) begin
                cnt_d    = '0;
                primed_d = 1'b0;
                state_d  = RUN;
            end else if (cnt_q == CW'(2*DELAY-1)) begin
                cnt_d    = '0;
                primed_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (flush && cnt_q == '0 && primed_q) begin
            state_d = FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            ptr_q       <= '0;
            primed_q    <= 1'b0;
            dout_re_q   <= '0;
            dout_im_q   <= '0;
            valid_out_q <= 1'b0;
            sof_out_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            primed_q    <= primed_d;
            dout_re_q   <= dout_re_d;
            dout_im_q   <= dout_im_d;
            valid_out_q <= valid_out_d;
            sof_out_q   <= sof_out_d;
            err_q       <= err_d;
        end
    end

    // Line contents need no reset: nothing is emitted before it is written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_re[ptr_q] <= push_re;
            mem_im[ptr_q] <= push_im;
        end
    end

    assign dout_re    = dout_re_q;
    assign dout_im    = dout_im_q;
    assign valid_out  = valid_out_q;
    assign sof_out    = sof_out_q;
    assign err_resync = err_q;
    assign busy       = (state_q == FLUSH);

endmodule

// File: tb/tb_bf2_sdf_stage.sv
// Bench for bf2_sdf_stage: spec vector table, hand corner cases,
// and random traffic against an index-based frame model.
module tb_bf2_sdf_stage;

    localparam int IW = 9;
    localparam int D  = 4;
    localparam int OW = IW + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [IW-1:0] din_re = '0, din_im = '0;
    logic          valid_in = 1'b0, sof_in = 1'b0;
    logic          scale_en = 1'b0, flush = 1'b0;
    logic [OW-1:0] dout_re, dout_im;
    logic          valid_out, sof_out, busy, err_resync;

    bf2_sdf_stage #(.IN_W(IW), .DELAY(D)) dut (
        .clk(clk), .rstn(rstn),
        .din_re(din_re), .din_im(din_im),
        .valid_in(valid_in), .sof_in(sof_in),
        .scale_en(scale_en), .flush(flush),
        .dout_re(dout_re), .dout_im(dout_im),
        .valid_out(valid_out), .sof_out(sof_out),
        .busy(busy), .err_resync(err_resync)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int chks = 0;

    // Model: first-half samples and differences stored by frame index.
    int  m_idx, m_fcnt;
    bit  m_primed, m_flush;
    int  fr[D], fi[D], dr[D], di[D];
    bit  e_valid, e_sof, e_err, e_busy;
    int  e_re, e_im;
    int  cap[$];

    task automatic chk(input string nm,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        chks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    function automatic int scl(input int v, input bit s);
        return s ? ((v + 1) >>> 1) : v;
    endfunction

    task automatic m_reset();
        m_idx = 0; m_fcnt = 0; m_primed = 0; m_flush = 0;
        e_valid = 0; e_sof = 0; e_err = 0; e_busy = 0;
        for (int i = 0; i < D; i++) begin
            fr[i] = 0; fi[i] = 0; dr[i] = 0; di[i] = 0;
        end
    endtask

    task automatic m_step(input bit vin, input bit sof,
                          input bit fl, input bit sc,
                          input int xr, input int xi);
        int k;
        e_valid = 0; e_sof = 0; e_err = 0;
        if (m_flush) begin
            e_re = scl(dr[m_fcnt], sc);
            e_im = scl(di[m_fcnt], sc);
            e_valid = 1;
            m_fcnt++;
            if (m_fcnt == D) begin
                m_flush = 0; m_primed = 0; m_idx = 0;
            end
        end else if (vin) begin
            if (sof && m_idx != 0) begin
                e_err = 1; m_idx = 0; m_primed = 0;
            end
            if (m_idx < D) begin
                fr[m_idx] = xr; fi[m_idx] = xi;
                e_re = scl(dr[m_idx], sc);
                e_im = scl(di[m_idx], sc);
                e_valid = m_primed;
            end else begin
                k = m_idx - D;
                e_re = scl(fr[k] + xr, sc);
                e_im = scl(fi[k] + xi, sc);
                dr[k] = fr[k] - xr;
                di[k] = fi[k] - xi;
                e_valid = 1;
                e_sof = (k == 0);
            end
            m_idx++;
            if (m_idx == 2*D) begin
                m_idx = 0; m_primed = 1;
            end
        end else if (fl && m_idx == 0 && m_primed) begin
            m_flush = 1; m_fcnt = 0;
        end
        e_busy = m_flush;
    endtask

    task automatic cyc(input bit vin, input bit sof, input bit fl,
                       input bit sc, input int xr, input int xi);
        valid_in = vin; sof_in = sof; flush = fl; scale_en = sc;
        din_re = xr[IW-1:0];
        din_im = xi[IW-1:0];
        @(posedge clk);
        m_step(vin, sof, fl, sc, xr, xi);
        #1;
        chk("valid_out", valid_out, e_valid);
        chk("sof_out", sof_out, e_sof);
        chk("err_resync", err_resync, e_err);
        chk("busy", busy, e_busy);
        if (e_valid) begin
            chk("dout_re", $signed(dout_re), e_re);
            chk("dout_im", $signed(dout_im), e_im);
        end
        if (valid_out) cap.push_back(int'($signed(dout_re)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_re", dout_re, 0);
        chk("rst_im", dout_im, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_sof", sof_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_resync, 0);
        m_reset();
        valid_in = 0; sof_in = 0; flush = 0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    typedef struct {
        bit vin, sof, fl;
        int re;
        bit ev;
        int ere;
        bit esof, ebusy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit vin, input bit sof, input bit fl,
                       input int re, input bit ev, input int ere,
                       input bit esof, input bit ebusy);
        vec_t v;
        v.vin = vin; v.sof = sof; v.fl = fl; v.re = re;
        v.ev = ev; v.ere = ere; v.esof = esof; v.ebusy = ebusy;
        tbl.push_back(v);
    endtask

    task automatic add_frame_a(input bit pv, input int pd);
        for (int i = 0; i < D; i++)
            add(1, i == 0, 0, i + 1, pv, pd, 0, 0);
        for (int i = D; i < 2*D; i++)
            add(1, 0, 0, i + 1, 1, 2*i - 2, i == D, 0);
    endtask

    initial begin
        int seq[8];
        int xs[8];
        int exp_cap[4];
        int n;

        m_reset();
        do_reset();

        cyc(1, 1, 0, 0, 37, -5);
        cyc(1, 0, 0, 0, -12, 9);
        do_reset();

        add_frame_a(0, 0);
        for (int i = 0; i < D; i++) add(1, i == 0, 0, 0, 1, -4, 0, 0);
        for (int i = 0; i < D; i++) add(1, 0, 0, 0, 1, 0, i == 0, 0);
        add_frame_a(1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < D; i++) add(0, 0, 0, 0, 1, -4, 0, i != D-1);
        add_frame_a(0, 0);

        foreach (tbl[j]) begin
            cyc(tbl[j].vin, tbl[j].sof, tbl[j].fl, 0, tbl[j].re, 0);
            chk("tbl_valid", valid_out, tbl[j].ev);
            chk("tbl_sof", sof_out, tbl[j].esof);
            chk("tbl_busy", busy, tbl[j].ebusy);
            if (tbl[j].ev) chk("tbl_re", $signed(dout_re), tbl[j].ere);
        end

        xs = '{255, -256, 255, 0, 255, -255, -256, 0};
        for (int s = 1; s >= 0; s--) begin
            for (int i = 0; i < 2*D; i++) begin
                cyc(1, i == 0, 0, s[0], xs[i], 0);
                if (i == 4) chk("pair0_sum", $signed(dout_re),
                                s ? 255 : 510);
                if (i == 5) chk("pair1_sum", $signed(dout_re),
                                s ? -255 : -511);
            end
            cyc(0, 0, 1, s[0], 0, 0);
            for (int i = 0; i < D; i++) begin
                cyc(0, 0, 0, s[0], 0, 0);
                if (i == 2) chk("pair2_diff", $signed(dout_re),
                                s ? 256 : 511);
            end
        end

        cap.delete();
        for (int i = 0; i < 2*D; i++) begin
            n = 0;
            while ($urandom_range(0, 1) == 1 && n < 4) begin
                cyc(0, 0, 0, 0, 99, 0);
                n++;
            end
            cyc(1, i == 0, 0, 0, i + 1, 0);
        end
        exp_cap = '{6, 8, 10, 12};
        chk("stall_count", cap.size(), 4);
        for (int i = 0; i < 4 && i < cap.size(); i++)
            chk("stall_seq", cap[i], exp_cap[i]);

        cyc(1, 1, 0, 0, 3, 1);
        cyc(1, 0, 0, 0, 4, 2);
        cyc(1, 1, 0, 0, 5, 3);
        chk("resync_pulse", err_resync, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("resync_once", err_resync, 0);
        for (int i = 1; i < 2*D; i++) cyc(1, 0, 0, 0, 10*i, -i);

        for (int c = 0; c < 600; c++) begin
            bit vin, sof, fl;
            vin = ($urandom_range(0, 9) < 7);
            sof = vin && (m_idx == 0 || $urandom_range(0, 49) == 0);
            fl  = !vin && ($urandom_range(0, 4) == 0);
            cyc(vin, sof, fl, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 511)) - 256,
                int'($urandom_range(0, 511)) - 256);
        end

        for (int c = 0; c < 3*D && (m_flush || m_idx != 0); c++)
            cyc(!m_flush, 0, 0, 0, 1, 1);
        for (int i = 0; i < 2*D; i++)
            cyc(1, i == 0, 0, 0, 20 + i, 7 - i);
        cyc(0, 0, 1, 0, 0, 0);
        chk("flush_start", busy, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 2*D; i++) cyc(1, i == 0, 0, 0, i - 3, i);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
